// File: rtl/voice_mixer.sv
// Accumulates one frame of enveloped voice samples and presents the scaled mix on a valid/ready register.
// Build option: MIXER_SATURATE_EN clamps the scaled sum to 16 bits instead of wrapping.
module voice_mixer #(
   parameter int NUM_VOICES = 16,
   parameter int GAIN_SHIFT = 4,
   parameter int ACC_WIDTH  = 24
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic [1:0]  i_pipeline_state,
   input  logic [7:0]  i_voice_index,
   input  logic [15:0] i_sample,
   input  logic        i_sample_ready,
   input  logic        i_clear_flags,
   output logic [15:0] o_sample,
   output logic        o_sample_valid,
   output logic        o_overrun,
   output logic        o_frame_error
);

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [7:0]                  cnt_q, cnt_d;
   logic                        synced_q, synced_d;
   logic [15:0]                 sample_q, sample_d;
   logic                        valid_q, valid_d;
   logic                        overrun_q, overrun_d;
   logic                        ferr_q, ferr_d;

   logic                        cap;
   logic                        idx0;
   logic                        take;
   logic                        in_range;
   logic                        last;
   logic                        frame_end;
   logic signed [ACC_WIDTH-1:0] s_ext;
   logic signed [ACC_WIDTH-1:0] total;
   logic [8:0]                  cnt_next;
   logic [15:0]                 mix_r;

   assign cap      = (i_pipeline_state == 2'd2);
   assign idx0     = (i_voice_index == 8'd0);
   assign take     = cap && (synced_q || idx0);
   assign in_range = int'(i_voice_index) < NUM_VOICES;
   assign last     = int'(i_voice_index) == NUM_VOICES - 1;
   assign s_ext    = {{(ACC_WIDTH-16){i_sample[15]}}, i_sample};
   assign total    = (idx0 ? '0 : acc_q) + s_ext;
   assign cnt_next = idx0 ? 9'd1 : {1'b0, cnt_q} + 9'd1;
   assign frame_end = take && in_range && last;

`ifdef MIXER_SATURATE_EN
   localparam logic signed [ACC_WIDTH-1:0] MAX_R = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] MIN_R = ~MAX_R;

   logic signed [ACC_WIDTH-1:0] r;

   assign r = total >>> GAIN_SHIFT;

   always_comb begin
      if (r > MAX_R)
         mix_r = 16'h7FFF;
      else if (r < MIN_R)
         mix_r = 16'h8000;
      else
         mix_r = 16'(r);
   end
`else
   assign mix_r = 16'(total >>> GAIN_SHIFT);
`endif

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      synced_d  = synced_q;
      sample_d  = sample_q;
      valid_d   = valid_q;
      overrun_d = overrun_q & ~i_clear_flags;
      ferr_d    = ferr_q & ~i_clear_flags;

      if (take) begin
         synced_d = 1'b1;
         if (!in_range) begin
            ferr_d = 1'b1;
         end else begin
            acc_d = total;
            cnt_d = cnt_next[8] ? 8'hFF : cnt_next[7:0];
            if (last && (int'(cnt_next) != NUM_VOICES))
               ferr_d = 1'b1;
         end
      end

      // A finished frame takes the register only if it is free or being drained.
      if (frame_end) begin
         if (!valid_q || i_sample_ready) begin
            sample_d = mix_r;
            valid_d  = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && i_sample_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         synced_q  <= 1'b0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         synced_q  <= synced_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   assign o_sample       = sample_q;
   assign o_sample_valid = valid_q;
   assign o_overrun      = overrun_q;
   assign o_frame_error  = ferr_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: 4 voices, gain shift 2 (main) and 0 (wrap/clamp check).
module tb_voice_mixer;

   logic        clk;
   logic        rst_n;
   logic [1:0]  st;
   logic [7:0]  vidx;
   logic [15:0] smp;
   logic        rdy;
   logic        clr;

   logic [15:0] o_smp, o_smp0;
   logic        o_vld, o_vld0;
   logic        o_ovr, o_ovr0;
   logic        o_ferr, o_ferr0;

   int n_cmp;
   int n_bad;
   int exp_big;

   voice_mixer #(
      .NUM_VOICES(4),
      .GAIN_SHIFT(2),
      .ACC_WIDTH (24)
   ) u_dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_pipeline_state(st),
      .i_voice_index   (vidx),
      .i_sample        (smp),
      .i_sample_ready  (rdy),
      .i_clear_flags   (clr),
      .o_sample        (o_smp),
      .o_sample_valid  (o_vld),
      .o_overrun       (o_ovr),
      .o_frame_error   (o_ferr)
   );

   voice_mixer #(
      .NUM_VOICES(4),
      .GAIN_SHIFT(0),
      .ACC_WIDTH (24)
   ) u_dut0 (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_pipeline_state(st),
      .i_voice_index   (vidx),
      .i_sample        (smp),
      .i_sample_ready  (rdy),
      .i_clear_flags   (clr),
      .o_sample        (o_smp0),
      .o_sample_valid  (o_vld0),
      .o_overrun       (o_ovr0),
      .o_frame_error   (o_ferr0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Read and compute phases carry junk that must be ignored; ready can be
   // raised for the capture cycle only.
   task automatic slot(input int idx, input int val, input logic rdy_cap);
      vidx = idx[7:0];
      smp  = 16'd12345;
      st   = 2'd0;
      tick(1);
      st   = 2'd1;
      tick(1);
      smp  = val[15:0];
      st   = 2'd2;
      rdy  = rdy_cap;
      tick(1);
      rdy  = 1'b0;
      st   = 2'd3;
   endtask

   task automatic frame(input int a, input int b, input int c, input int d);
      slot(0, a, 1'b0);
      slot(1, b, 1'b0);
      slot(2, c, 1'b0);
      slot(3, d, 1'b0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      st    = 2'd3;
      vidx  = '0;
      smp   = '0;
      rdy   = 1'b0;
      clr   = 1'b0;
`ifdef MIXER_SATURATE_EN
      exp_big = 32767;
`else
      exp_big = -4;
`endif
      tick(3);
      check("rst_sample", int'($signed(o_smp)), 0);
      check("rst_valid", int'(o_vld), 0);
      check("rst_ovr", int'(o_ovr), 0);
      check("rst_ferr", int'(o_ferr), 0);
      rst_n = 1'b1;
      tick(2);

      frame(1000, 2000, -500, 1500);
      check("mix_a_sample", int'($signed(o_smp)), 1000);
      check("mix_a_valid", int'(o_vld), 1);
      check("mix_a_ferr", int'(o_ferr), 0);
      check("mix_a_ovr", int'(o_ovr), 0);
      tick(3);
      check("hold_sample", int'($signed(o_smp)), 1000);
      check("hold_valid", int'(o_vld), 1);

      frame(800, 800, 800, 800);
      check("ovr_keep", int'($signed(o_smp)), 1000);
      check("ovr_valid", int'(o_vld), 1);
      check("ovr_flag", int'(o_ovr), 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("ovr_clear", int'(o_ovr), 0);
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      check("drain_valid", int'(o_vld), 0);
      check("drain_sample", int'($signed(o_smp)), 1000);

      slot(0, 400, 1'b0);
      slot(1, 400, 1'b0);
      slot(3, 400, 1'b0);
      check("skip_sample", int'($signed(o_smp)), 300);
      check("skip_valid", int'(o_vld), 1);
      check("skip_ferr", int'(o_ferr), 1);
      check("skip_ovr", int'(o_ovr), 0);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("ferr_clear", int'(o_ferr), 0);
      slot(7, 0, 1'b0);
      check("idx7_ferr", int'(o_ferr), 1);
      clr = 1'b1;
      slot(7, 0, 1'b0);
      clr = 1'b0;
      check("set_wins", int'(o_ferr), 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("ferr_clear2", int'(o_ferr), 0);

      slot(0, -400, 1'b0);
      slot(1, -400, 1'b0);
      slot(2, -400, 1'b0);
      check("pre_rdy_valid", int'(o_vld), 1);
      slot(3, -400, 1'b1);
      check("rdy_end_sample", int'($signed(o_smp)), -400);
      check("rdy_end_valid", int'(o_vld), 1);
      check("rdy_end_ovr", int'(o_ovr), 0);
      check("rdy_end_ferr", int'(o_ferr), 0);
      rdy = 1'b1;
      tick(1);
      rdy = 1'b0;
      check("drain2_valid", int'(o_vld), 0);

      frame(32767, 32767, 32767, 32767);
      check("big_g2_sample", int'($signed(o_smp)), 32767);
      check("big_g0_sample", int'($signed(o_smp0)), exp_big);
      check("big_g0_valid", int'(o_vld0), 1);

      slot(7, 0, 1'b0);
      slot(0, 100, 1'b0);
      slot(1, 100, 1'b0);
      check("pre_rst_ferr", int'(o_ferr), 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_sample", int'($signed(o_smp)), 0);
      check("arst_valid", int'(o_vld), 0);
      check("arst_ferr", int'(o_ferr), 0);
      check("arst_ovr", int'(o_ovr), 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      slot(2, 100, 1'b0);
      slot(3, 100, 1'b0);
      check("unsync_valid", int'(o_vld), 0);
      check("unsync_ferr", int'(o_ferr), 0);
      frame(800, 800, 800, 800);
      check("resync_sample", int'($signed(o_smp)), 800);
      check("resync_valid", int'(o_vld), 1);
      check("resync_ferr", int'(o_ferr), 0);
      check("resync_ovr", int'(o_ovr), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
